// File: rtl/uart_pkg.sv
// UART shared package: receiver FSM encodings, baud
// divider helpers and the baud-counter width expression.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    Idle   = 3'd0,
    Start  = 3'd1,
    Data   = 3'd2,
    Stop   = 3'd3,
    Parity = 3'd4
  } rx_state_t;
`else
  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Start = 2'd1,
    Data  = 2'd2,
    Stop  = 2'd3
  } rx_state_t;
`endif

  function automatic int baud_div(
    input int clk_rate,
    input int baud
  );
    return clk_rate / baud;
  endfunction

  function automatic int half_div(
    input int clk_rate,
    input int baud
  );
    return (clk_rate / baud) / 2;
  endfunction

  function automatic int baud_cnt_w(input int div);
    return $clog2(div) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_axis_if.sv
// Receive stream port: word, valid/ready handshake
// and the one-cycle error pulses.
interface uart_rx_axis_if #(
  parameter int W = 8
);
  logic [W-1:0] rx_data;
  logic         rx_data_valid;
  logic         rx_data_ready;
  logic         frame_err;
  logic         overrun_err;

  modport master (
    output rx_data,
    output rx_data_valid,
    output frame_err,
    output overrun_err,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_data_valid,
    input  frame_err,
    input  overrun_err,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus a
// falling-edge detector; all flops reset to idle-high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic rx_s,
  output logic fall
);

  logic rx_q1;
  logic rx_s_d;

  // metastability chain and one-cycle delay for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_q1  <= rx_in;
      rx_s   <= rx_q1;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

endmodule

// File: rtl/uart_rx_axis.sv
// UART receiver with valid/ready output, centre sampling.
// Optional parity stage enabled by macro UART_RX_PARITY_EN.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int clk_rate = 100000000,
  parameter int Baud     = 115200,
  parameter int Word_len = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit Parity_odd = 1'b0
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Uart_rx,
`ifdef UART_RX_PARITY_EN
  output logic parity_err,
`endif
  uart_rx_axis_if.master axis
);

  localparam int BaudDiv = baud_div(clk_rate, Baud);
  localparam int HalfDiv = half_div(clk_rate, Baud);
  localparam int CntW    = baud_cnt_w(BaudDiv);
  localparam int BitW    = $clog2(Word_len + 1);

  localparam logic [CntW-1:0] FullTc = CntW'(BaudDiv - 1);
  localparam logic [CntW-1:0] HalfTc = CntW'(HalfDiv - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(Word_len - 1);

  logic rx_s;
  logic fall;

  rx_state_t             state, state_n;
  logic [CntW-1:0]       baud_cnt, cnt_n;
  logic [BitW-1:0]       bit_cnt, bit_n;
  logic [Word_len-1:0]   shift_reg, shift_n;
  logic [Word_len-1:0]   data_q, data_n;
  logic                  valid_q, valid_n;
  logic                  ferr_q, ferr_n;
  logic                  oerr_q, oerr_n;
`ifdef UART_RX_PARITY_EN
  logic                  par_q, par_n;
  logic                  perr_q, perr_n;
`endif

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_in (Uart_rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  // state, counters, shifter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= Idle;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      baud_cnt  <= cnt_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      data_q    <= data_n;
      valid_q   <= valid_n;
      ferr_q    <= ferr_n;
      oerr_q    <= oerr_n;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_n;
      perr_q    <= perr_n;
`endif
    end
  end

  // next-state, bit timing and stop-bit word delivery
  always_comb begin
    state_n = state;
    cnt_n   = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    data_n  = data_q;
    valid_n = valid_q & ~axis.rx_data_ready;
    ferr_n  = 1'b0;
    oerr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_q;
    perr_n  = 1'b0;
`endif
    unique case (state)
      Idle: begin
        cnt_n = '0;
        bit_n = '0;
        if (fall) state_n = Start;
      end
      Start: begin
        if (baud_cnt == HalfTc) begin
          cnt_n   = '0;
          state_n = rx_s ? Idle : Data;
        end else begin
          cnt_n = baud_cnt + CntW'(1);
        end
      end
      Data: begin
        if (baud_cnt == FullTc) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift_reg[Word_len-1:1]};
          if (bit_cnt == LastBit) begin
            bit_n = '0;
`ifdef UART_RX_PARITY_EN
            state_n = Parity;
`else
            state_n = Stop;
`endif
          end else begin
            bit_n = bit_cnt + BitW'(1);
          end
        end else begin
          cnt_n = baud_cnt + CntW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      Parity: begin
        if (baud_cnt == FullTc) begin
          cnt_n   = '0;
          par_n   = rx_s;
          state_n = Stop;
        end else begin
          cnt_n = baud_cnt + CntW'(1);
        end
      end
`endif
      Stop: begin
        if (baud_cnt == FullTc) begin
          cnt_n   = '0;
          state_n = Idle;
          if (!rx_s) begin
            ferr_n = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if ((^{shift_reg, par_q}) != Parity_odd) begin
            perr_n = 1'b1;
`endif
          end else if (!valid_q || axis.rx_data_ready) begin
            data_n  = shift_reg;
            valid_n = 1'b1;
          end else begin
            oerr_n = 1'b1;
          end
        end else begin
          cnt_n = baud_cnt + CntW'(1);
        end
      end
      default: begin
        state_n = Idle;
        cnt_n   = '0;
        bit_n   = '0;
      end
    endcase
  end

  assign axis.rx_data       = data_q;
  assign axis.rx_data_valid = valid_q;
  assign axis.frame_err     = ferr_q;
  assign axis.overrun_err   = oerr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err         = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_axis.sv
// Directed bench for uart_rx_axis at Baud_div=10:
// clean, overrun, framing, glitch and reset cases.
module tb_uart_rx_axis;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;

  uart_rx_axis_if #(.W(8)) axis ();

`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  uart_rx_axis #(
    .clk_rate (1000000),
    .Baud     (100000),
    .Word_len (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Uart_rx    (rx),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .axis       (axis)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int acc = 0;
  int vcnt = 0;
  int fcnt = 0;
  int ocnt = 0;
  int pcnt = 0;
  logic [7:0] last = '0;

  int acc0, vcnt0, fcnt0, ocnt0, pcnt0;

  // observe stream and flags away from the active edge
  always @(negedge clk) begin
    if (axis.rx_data_valid) vcnt++;
    if (axis.rx_data_valid && axis.rx_data_ready) begin
      acc++;
      last = axis.rx_data;
    end
    if (axis.frame_err) fcnt++;
    if (axis.overrun_err) ocnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pcnt++;
`endif
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [7:0] d,
    input logic       stop,
    input logic       use_par,
    input logic       par
  );
    line(1'b0, 10);
    for (int i = 0; i < 8; i++) line(d[i], 10);
    if (use_par) line(par, 10);
    line(stop, 10);
  endtask

  task automatic snap();
    acc0  = acc;
    vcnt0 = vcnt;
    fcnt0 = fcnt;
    ocnt0 = ocnt;
    pcnt0 = pcnt;
  endtask

  initial begin
    axis.rx_data_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(axis.rx_data), 32'h0);
    chk("rst_valid", 32'(axis.rx_data_valid), 32'h0);
    chk("rst_ferr", 32'(axis.frame_err), 32'h0);
    chk("rst_oerr", 32'(axis.overrun_err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    line(1'b1, 20);

    // clean frame, consumer always ready
    snap();
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    line(1'b1, 20);
    chk("a5_acc", 32'(acc - acc0), 32'd1);
    chk("a5_data", 32'(last), 32'hA5);
    chk("a5_vpulse", 32'(vcnt - vcnt0), 32'd1);
    chk("a5_ferr", 32'(fcnt - fcnt0), 32'd0);
    chk("a5_oerr", 32'(ocnt - ocnt0), 32'd0);

    // back-to-back frames with consumer stalled
    axis.rx_data_ready = 1'b0;
    snap();
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    send(8'hC3, 1'b1, 1'b0, 1'b0);
    line(1'b1, 20);
    chk("ov_valid", 32'(axis.rx_data_valid), 32'd1);
    chk("ov_hold", 32'(axis.rx_data), 32'h3C);
    chk("ov_oerr", 32'(ocnt - ocnt0), 32'd1);
    chk("ov_acc0", 32'(acc - acc0), 32'd0);
    axis.rx_data_ready = 1'b1;
    line(1'b1, 3);
    chk("ov_acc1", 32'(acc - acc0), 32'd1);
    chk("ov_last", 32'(last), 32'h3C);
    chk("ov_drop", 32'(axis.rx_data_valid), 32'd0);

    // framing error then long break, no retrigger
    snap();
    send(8'h55, 1'b0, 1'b0, 1'b0);
    line(1'b0, 300);
    chk("fe_ferr", 32'(fcnt - fcnt0), 32'd1);
    chk("fe_valid", 32'(vcnt - vcnt0), 32'd0);
    line(1'b1, 20);
    send(8'h0F, 1'b1, 1'b0, 1'b0);
    line(1'b1, 20);
    chk("fe_acc", 32'(acc - acc0), 32'd1);
    chk("fe_data", 32'(last), 32'h0F);
    chk("fe_ferr2", 32'(fcnt - fcnt0), 32'd1);

    // short low glitch on idle line
    snap();
    line(1'b0, 3);
    line(1'b1, 40);
    chk("gl_valid", 32'(vcnt - vcnt0), 32'd0);
    chk("gl_ferr", 32'(fcnt - fcnt0), 32'd0);
    chk("gl_oerr", 32'(ocnt - ocnt0), 32'd0);
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    line(1'b1, 20);
    chk("gl_data", 32'(last), 32'h5A);
    chk("gl_acc", 32'(acc - acc0), 32'd1);

    // reset in the middle of bit 4
    snap();
    line(1'b0, 10);
    line(1'b1, 45);
    rst_n = 1'b0;
    line(1'b1, 2);
    chk("mr_data", 32'(axis.rx_data), 32'h0);
    chk("mr_valid", 32'(axis.rx_data_valid), 32'h0);
    chk("mr_ferr", 32'(axis.frame_err), 32'h0);
    chk("mr_oerr", 32'(axis.overrun_err), 32'h0);
    line(1'b1, 5);
    rst_n = 1'b1;
    line(1'b1, 40);
    chk("mr_none", 32'(acc - acc0), 32'd0);
    send(8'h81, 1'b1, 1'b0, 1'b0);
    line(1'b1, 20);
    chk("mr_acc", 32'(acc - acc0), 32'd1);
    chk("mr_last", 32'(last), 32'h81);
    chk("mr_ferr2", 32'(fcnt - fcnt0), 32'd0);

`ifdef UART_RX_PARITY_EN
    // even parity: 0x07 needs parity bit 1
    snap();
    send(8'h07, 1'b1, 1'b1, 1'b0);
    line(1'b1, 20);
    chk("pe_perr", 32'(pcnt - pcnt0), 32'd1);
    chk("pe_acc", 32'(acc - acc0), 32'd0);
    snap();
    send(8'h07, 1'b1, 1'b1, 1'b1);
    line(1'b1, 20);
    chk("po_acc", 32'(acc - acc0), 32'd1);
    chk("po_data", 32'(last), 32'h07);
    chk("po_perr", 32'(pcnt - pcnt0), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
